// File: rtl/y_writer.sv
// y_writer: buffers finished rows, converts FloPoCo doubles to IEEE-754 and
// writes them as consecutive 8-byte words starting at base_addr.
module y_writer #(
  parameter int DEPTH       = 64,
  parameter int STALL_SLACK = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_to_y,
  input  logic [65:0] v_to_y,
  input  logic        eof,
  input  logic [47:0] base_addr,
  output logic        stall_out,
  output logic        mem_req,
  output logic [47:0] mem_addr,
  output logic [63:0] mem_data,
  input  logic        mem_stall,
  output logic        done,
  output logic        overflow
);
  localparam int AW = $clog2(DEPTH);
  logic [65:0]   r_mem [DEPTH];
  logic [AW-1:0] r_rd, r_wr;
  logic [AW:0]   r_cnt, w_cnt_nxt;
  logic [44:0]   r_idx;
  logic          r_eof_seen;
  logic          w_xfer, w_pop, w_wr, w_full;
  logic [65:0]   w_head;
  logic [63:0]   w_conv;
  assign w_xfer    = mem_req && !mem_stall;
  assign w_pop     = (r_cnt != '0) && (!mem_req || w_xfer);
  assign w_full    = r_cnt == (AW+1)'(DEPTH);
  // a push into a full FIFO is still accepted when a pop frees a slot this edge
  assign w_wr      = push_to_y && (!w_full || w_pop);
  assign w_cnt_nxt = r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_pop);
  assign w_head    = r_mem[r_rd];
  assign w_conv    = w_head[65:64] == 2'b00 ? {w_head[63], 63'b0} :
                     w_head[65:64] == 2'b01 ? w_head[63:0] :
                     w_head[65:64] == 2'b10 ? {w_head[63], 11'h7FF, 52'b0} :
                                              64'h7FF8_0000_0000_0000;
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wr] <= v_to_y;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_rd       <= '0;
      r_wr       <= '0;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_eof_seen <= 1'b0;
      stall_out  <= 1'b0;
      overflow   <= 1'b0;
      done       <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      stall_out <= w_cnt_nxt >= (AW+1)'(DEPTH - STALL_SLACK);
      if (w_wr) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      if (push_to_y && !w_wr) overflow <= 1'b1;
      if (eof) r_eof_seen <= 1'b1;
      if (r_eof_seen && r_cnt == '0 && !mem_req && !push_to_y) done <= 1'b1;
      if (w_pop) begin
        mem_req  <= 1'b1;
        mem_addr <= base_addr + {r_idx, 3'b000};
        mem_data <= w_conv;
        r_idx    <= r_idx + 1'b1;
      end else if (w_xfer) mem_req <= 1'b0;
    end
endmodule

// File: tb/tb_y_writer.sv
// tb_y_writer: directed stimulus; a queue of expected IEEE words plus a running
// write index model every transfer, with literal spot checks per scenario.
module tb_y_writer;
  logic        clk = 0, rst = 1, push_to_y = 0, eof = 0, mem_stall = 0;
  logic [65:0] v_to_y = '0;
  logic [47:0] base_addr = '0;
  logic        stall_out, mem_req, done, overflow;
  logic [47:0] mem_addr;
  logic [63:0] mem_data;
  int          ncmp = 0, nerr = 0;
  logic [63:0] expq[$];
  logic [47:0] xa[$];
  logic [63:0] xd[$];
  logic [44:0] nx = '0;
  logic        p_req = 0, p_stall = 0, p_done = 0;
  logic [47:0] p_addr = '0;
  logic [63:0] p_data = '0;

  y_writer #(.DEPTH(64), .STALL_SLACK(8)) dut (
    .clk(clk), .rst(rst), .push_to_y(push_to_y), .v_to_y(v_to_y), .eof(eof),
    .base_addr(base_addr), .stall_out(stall_out), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_stall(mem_stall),
    .done(done), .overflow(overflow));

  always #5 clk = ~clk;

  function automatic logic [63:0] conv(input logic [65:0] v);
    case (v[65:64])
      2'b00:   return {v[63], 63'b0};
      2'b01:   return v[63:0];
      2'b10:   return {v[63], 11'h7FF, 52'b0};
      default: return 64'h7FF8_0000_0000_0000;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic p, input logic [65:0] v, input logic e, input logic acc);
    @(posedge clk); #1;
    push_to_y = p;
    v_to_y    = v;
    eof       = e;
    if (p && acc) expq.push_back(conv(v));
  endtask

  task automatic do_reset;
    rst = 1; push_to_y = 0; eof = 0; mem_stall = 0;
    expq.delete(); xa.delete(); xd.delete(); nx = '0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic wait_drain(input int lim);
    int k = 0;
    while (expq.size() != 0 && k < lim) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    chk("drain_left", 64'(expq.size()), 0);
  endtask

  // every transfer must match the next expected word at base + 8*n
  always @(negedge clk) begin
    if (rst) begin
      p_req = 0; p_stall = 0; p_done = 0;
    end else begin
      if (p_req && p_stall) begin
        chk("hold_req", 64'(mem_req), 1);
        chk("hold_addr", 64'(mem_addr), 64'(p_addr));
        chk("hold_data", mem_data, p_data);
      end
      if (p_done) chk("done_sticky", 64'(done), 1);
      if (mem_req && !mem_stall) begin
        if (expq.size() == 0) begin
          ncmp++; nerr++;
          $display("FAIL xfer_extra: got write addr %h expected none", mem_addr);
        end else begin
          chk("xfer_data", mem_data, expq.pop_front());
          chk("xfer_addr", 64'(mem_addr), 64'(base_addr + {nx, 3'b000}));
        end
        nx++;
        xa.push_back(mem_addr);
        xd.push_back(mem_data);
      end
      p_req = mem_req; p_stall = mem_stall; p_done = done;
      p_addr = mem_addr; p_data = mem_data;
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 64'(mem_req), 0);
    chk("rst_addr", 64'(mem_addr), 0);
    chk("rst_data", mem_data, 0);
    chk("rst_stall", 64'(stall_out), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_ovf", 64'(overflow), 0);

    // single value: latency 2, then eof -> done
    base_addr = 48'h1000;
    do_reset;
    cyc(1, 66'h1_3FF0_0000_0000_0000, 0, 1);
    cyc(0, '0, 0, 0);
    @(negedge clk); chk("single_lat1", 64'(mem_req), 0);
    @(negedge clk); chk("single_req", 64'(mem_req), 1);
    chk("single_addr", 64'(mem_addr), 64'h1000);
    chk("single_data", mem_data, 64'h3FF0_0000_0000_0000);
    cyc(0, '0, 1, 0);
    cyc(0, '0, 0, 0);
    begin
      int k = 0;
      while (!done && k < 20) begin @(negedge clk); k++; end
    end
    chk("single_done", 64'(done), 1);

    // exception conversion
    base_addr = 48'h2000;
    do_reset;
    cyc(1, {2'b00, 1'b1, 63'h1234}, 0, 1);
    cyc(1, {2'b10, 1'b0, 63'h5555}, 0, 1);
    cyc(1, {2'b11, 64'h0123}, 0, 1);
    cyc(1, {2'b01, 64'h4009_21FB_5444_2D18}, 0, 1);
    cyc(0, '0, 0, 0);
    wait_drain(20);
    chk("exc_n", 64'(xa.size()), 4);
    chk("exc_d0", xd[0], 64'h8000_0000_0000_0000);
    chk("exc_d1", xd[1], 64'h7FF0_0000_0000_0000);
    chk("exc_d2", xd[2], 64'h7FF8_0000_0000_0000);
    chk("exc_d3", xd[3], 64'h4009_21FB_5444_2D18);
    chk("exc_a0", 64'(xa[0]), 64'h2000);
    chk("exc_a1", 64'(xa[1]), 64'h2008);
    chk("exc_a2", 64'(xa[2]), 64'h2010);
    chk("exc_a3", 64'(xa[3]), 64'h2018);

    // backpressure: first value parks in the output register, then 56 fill
    // the FIFO to the threshold, 8 more fill it, the next is dropped
    base_addr = 48'h0;
    do_reset;
    mem_stall = 1;
    for (int i = 0; i <= 65; i++) begin
      cyc(1, {2'b01, 64'h3FF0_0000_0000_0000 + 64'(i)}, 0, i < 65);
      @(negedge clk);
      chk("bp_stall", 64'(stall_out), 64'(i >= 57));
      chk("bp_ovf", 64'(overflow), 0);
    end
    cyc(0, '0, 0, 0);
    @(negedge clk);
    chk("bp_ovf_set", 64'(overflow), 1);
    chk("bp_stall_full", 64'(stall_out), 1);
    @(posedge clk); #1 mem_stall = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("bp_release_stall", 64'(stall_out), 64'(k < 9));
    end
    wait_drain(100);
    chk("bp_total", 64'(nx), 65);
    chk("bp_ovf_sticky", 64'(overflow), 1);

    // memory stall toggling mid-burst
    base_addr = 48'h8000_0000_1000;
    do_reset;
    fork
      begin
        for (int i = 0; i < 10; i++) cyc(1, {2'b01, 64'h4000_0000_0000_0000 + 64'(i)}, 0, 1);
        cyc(0, '0, 0, 0);
      end
      begin
        repeat (25) begin @(posedge clk); #1 mem_stall = 1'($urandom_range(0, 1)); end
        @(posedge clk); #1 mem_stall = 0;
      end
    join
    wait_drain(50);
    repeat (4) @(negedge clk);
    chk("burst_n", 64'(nx), 10);
    chk("burst_a0", 64'(xa[0]), 64'h8000_0000_1000);
    chk("burst_a9", 64'(xa[9]), 64'h8000_0000_1048);

    // completion: eof with the 5th push, done two cycles after the 5th transfer
    base_addr = 48'h3000;
    do_reset;
    for (int j = 0; j < 12; j++) begin
      cyc(j < 5, {2'b01, 64'(j + 1)}, j == 4, 1);
      @(negedge clk);
      chk("cmp_done", 64'(done), 64'(j >= 8));
      chk("cmp_req", 64'(mem_req), 64'(j >= 2 && j <= 6));
    end

    // reset with three values buffered
    do_reset;
    mem_stall = 1;
    for (int i = 0; i < 3; i++) cyc(1, {2'b01, 64'h55 + 64'(i)}, 0, 1);
    cyc(0, '0, 0, 0);
    @(negedge clk);
    chk("mid_pre_req", 64'(mem_req), 1);
    @(posedge clk); #1 rst = 1;
    expq.delete();
    #1;
    chk("mid_req", 64'(mem_req), 0);
    chk("mid_addr", 64'(mem_addr), 0);
    chk("mid_data", mem_data, 0);
    chk("mid_stall", 64'(stall_out), 0);
    chk("mid_done", 64'(done), 0);
    chk("mid_ovf", 64'(overflow), 0);
    @(posedge clk); #1 rst = 0; mem_stall = 0; nx = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("mid_no_req", 64'(mem_req), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
